// File: rtl/icu_wide.sv
// icu_wide: DATA_W-lane bit-serial style industrial control unit with a registered valid/ready output slot
module icu_wide #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        instruction,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] write,
    output logic [DATA_W-1:0] data_out,
    output logic              jmp,
    output logic              rtn,
    output logic              flag_o,
    output logic              flag_f,
    output logic              skipped,
    output logic [DATA_W-1:0] rr_out
);
    typedef enum logic [3:0] {
        OP_NOPO, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
        OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
    } op_e;

    op_e op;
    logic arm, acc, skip, sk_q;
    logic [DATA_W-1:0] rr, ien, oen, out, wr_q, d;
    logic [DATA_W-1:0] nr, nie, noe, nout, nwr;
    logic nskip;
    logic [3:0] stb_q, nstb;

    assign op       = op_e'(instruction);
    assign in_ready = ~out_valid | out_ready;
    // arm stays low on the edge that releases reset, so nothing is accepted there
    assign acc      = in_valid & in_ready & arm;
    assign d        = data_in & ien;
    assign write    = out_valid ? wr_q : '0;
    assign data_out = out & write;
    assign {jmp, rtn, flag_o, flag_f} = out_valid ? stb_q : 4'b0;
    assign skipped  = out_valid & sk_q;
    assign rr_out   = rr;

    // execute the presented instruction; a pending skip discards it instead
    always_comb begin
        nr    = rr;
        nie   = ien;
        noe   = oen;
        nout  = out;
        nskip = skip;
        nwr   = '0;
        nstb  = 4'b0;
        if (skip) begin
            nskip = 1'b0;
        end else begin
            case (op)
                OP_LD:   nr = d;
                OP_LDC:  nr = ~d;
                OP_AND:  nr = rr & d;
                OP_ANDC: nr = rr & ~d;
                OP_OR:   nr = rr | d;
                OP_ORC:  nr = rr | ~d;
                OP_XNOR: nr = rr ^ ~d;
                OP_STO:  begin nout = rr;  nwr = oen; end
                OP_STOC: begin nout = ~rr; nwr = oen; end
                OP_IEN:  nie = data_in;
                OP_OEN:  noe = d;
                OP_JMP:  nstb = 4'b1000;
                OP_RTN:  begin nstb = 4'b0100; nskip = 1'b1; end
                OP_SKZ:  nskip = (rr == '0);
                OP_NOPO: nstb = 4'b0010;
                OP_NOPF: nstb = 4'b0001;
                default: nr = rr;
            endcase
        end
    end

    // architectural state and the output slot update only on accept; slot drains on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm       <= 1'b0;
            rr        <= '0;
            ien       <= '0;
            oen       <= '0;
            out       <= '0;
            skip      <= 1'b0;
            out_valid <= 1'b0;
            wr_q      <= '0;
            stb_q     <= 4'b0;
            sk_q      <= 1'b0;
        end else begin
            arm <= 1'b1;
            if (acc) begin
                rr        <= nr;
                ien       <= nie;
                oen       <= noe;
                out       <= nout;
                skip      <= nskip;
                out_valid <= 1'b1;
                wr_q      <= nwr;
                stb_q     <= nstb;
                sk_q      <= skip;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_icu_wide.sv
// tb_icu_wide: table-driven scoreboard bench for icu_wide
module tb_icu_wide;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] instruction = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic in_ready, out_valid, jmp, rtn, flag_o, flag_f, skipped;
    logic [7:0] write, data_out, rr_out;
    logic [28:0] got;

    typedef struct {
        logic [3:0]  ins;
        logic [7:0]  dat;
        logic [28:0] exp;
    } vec_t;

    vec_t vec[64];
    vec_t q[$];
    int nv = 0;
    int checks = 0;
    int errors = 0;
    int cyc;
    int lo;

    always #5 clk = ~clk;

    icu_wide #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .write(write), .data_out(data_out), .jmp(jmp),
        .rtn(rtn), .flag_o(flag_o), .flag_f(flag_f), .skipped(skipped), .rr_out(rr_out)
    );

    assign got = {skipped, jmp, rtn, flag_o, flag_f, write, data_out, rr_out};

    task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, g, e);
        end
    endtask

    // record: opcode, operand, skipped, {jmp,rtn,flag_o,flag_f}, write, data_out, rr_out
    task automatic v(input logic [3:0] ins, input logic [7:0] dat, input logic skp,
                     input logic [3:0] stb, input logic [7:0] wr, input logic [7:0] dout,
                     input logic [7:0] rr);
        vec[nv] = '{ins, dat, {skp, stb, wr, dout, rr}};
        nv++;
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, "_outs"}, {35'd0, out_valid, got}, 64'd0);
        chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic release_rst();
        @(negedge clk);
        in_valid = 1'b1;
        instruction = 4'h1;
        data_in = 8'hFF;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("no_accept_on_release", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int first, input int last, input bit bp, output int ncyc);
        int idx;
        bit held;
        logic [29:0] snap;
        vec_t e;
        idx = first;
        held = 1'b0;
        snap = '0;
        ncyc = 0;
        while ((idx <= last || q.size() > 0) && ncyc < 500) begin
            in_valid = (idx <= last);
            if (idx <= last) begin
                instruction = vec[idx].ins;
                data_in = vec[idx].dat;
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("in_ready_eq", {63'd0, in_ready}, {63'd0, ~out_valid | out_ready});
            if (held) chk("stall_stable", {34'd0, out_valid, got}, {34'd0, snap});
            held = out_valid && !out_ready;
            snap = {out_valid, got};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_slot", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("slot_op%h_%h", e.ins, e.dat), {35'd0, got}, {35'd0, e.exp});
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(vec[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            ncyc++;
        end
        if (ncyc >= 500) chk("run_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_chk("reset_state");
        release_rst();

        v(4'hA, 8'hFF, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
        v(4'h1, 8'hA5, 0, 4'b0000, 8'h00, 8'h00, 8'hA5);
        v(4'hB, 8'hFF, 0, 4'b0000, 8'h00, 8'h00, 8'hA5);
        v(4'h8, 8'h00, 0, 4'b0000, 8'hFF, 8'hA5, 8'hA5);
        v(4'h9, 8'h00, 0, 4'b0000, 8'hFF, 8'h5A, 8'hA5);
        v(4'hA, 8'h0F, 0, 4'b0000, 8'h00, 8'h00, 8'hA5);
        v(4'h1, 8'hFF, 0, 4'b0000, 8'h00, 8'h00, 8'h0F);
        v(4'hB, 8'hF0, 0, 4'b0000, 8'h00, 8'h00, 8'h0F);
        v(4'h8, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'h0F);
        v(4'hA, 8'hFF, 0, 4'b0000, 8'h00, 8'h00, 8'h0F);
        v(4'hB, 8'h3C, 0, 4'b0000, 8'h00, 8'h00, 8'h0F);
        v(4'h3, 8'h33, 0, 4'b0000, 8'h00, 8'h00, 8'h03);
        v(4'h5, 8'hC0, 0, 4'b0000, 8'h00, 8'h00, 8'hC3);
        v(4'h7, 8'h0F, 0, 4'b0000, 8'h00, 8'h00, 8'h33);
        v(4'h4, 8'h21, 0, 4'b0000, 8'h00, 8'h00, 8'h12);
        v(4'h6, 8'hFE, 0, 4'b0000, 8'h00, 8'h00, 8'h13);
        v(4'h2, 8'h0F, 0, 4'b0000, 8'h00, 8'h00, 8'hF0);
        v(4'h8, 8'h00, 0, 4'b0000, 8'h3C, 8'h30, 8'hF0);
        v(4'h1, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
        v(4'hE, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
        v(4'h1, 8'h3C, 1, 4'b0000, 8'h00, 8'h00, 8'h00);
        v(4'h1, 8'h11, 0, 4'b0000, 8'h00, 8'h00, 8'h11);
        v(4'h1, 8'h01, 0, 4'b0000, 8'h00, 8'h00, 8'h01);
        v(4'hE, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'h01);
        v(4'h1, 8'h3C, 0, 4'b0000, 8'h00, 8'h00, 8'h3C);
        v(4'h1, 8'h11, 0, 4'b0000, 8'h00, 8'h00, 8'h11);
        v(4'hD, 8'h00, 0, 4'b0100, 8'h00, 8'h00, 8'h11);
        v(4'hC, 8'h00, 1, 4'b0000, 8'h00, 8'h00, 8'h11);
        v(4'hC, 8'h00, 0, 4'b1000, 8'h00, 8'h00, 8'h11);
        v(4'h0, 8'h00, 0, 4'b0010, 8'h00, 8'h00, 8'h11);
        v(4'hF, 8'h00, 0, 4'b0001, 8'h00, 8'h00, 8'h11);
        v(4'hE, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'h11);
        v(4'h9, 8'h00, 0, 4'b0000, 8'h3C, 8'h2C, 8'h11);
        run(0, nv - 1, 1'b1, cyc);

        in_valid = 1'b1;
        instruction = 4'hD;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("slot_pending", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk("reset_mid_slot");
        q.delete();
        @(posedge clk);
        #1;
        release_rst();

        lo = nv;
        v(4'h1, 8'h55, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
        v(4'hA, 8'hFF, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
        v(4'h1, 8'h55, 0, 4'b0000, 8'h00, 8'h00, 8'h55);
        v(4'h3, 8'h0F, 0, 4'b0000, 8'h00, 8'h00, 8'h05);
        v(4'h5, 8'hA0, 0, 4'b0000, 8'h00, 8'h00, 8'hA5);
        v(4'h2, 8'h00, 0, 4'b0000, 8'h00, 8'h00, 8'hFF);
        v(4'h7, 8'hFF, 0, 4'b0000, 8'h00, 8'h00, 8'hFF);
        v(4'h0, 8'h00, 0, 4'b0010, 8'h00, 8'h00, 8'hFF);
        run(lo, nv - 1, 1'b0, cyc);
        chk("throughput_cycles", 64'(cyc), 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
